// File: rtl/bouncing_square.sv
// bouncing_square
// Paints a solid square sprite over a background colour and bounces it
// between the screen edges. The square moves by SPEED pixels per axis on each
// qualifying frame pulse. Each axis is a two-state direction FSM (forward /
// reverse). All outputs are registered, so the colour lines up with a
// one-cycle-delayed sync path.
//
// Build option: define SQUARE_BORDER_EN to draw a BORDER-pixel frame in
// BORDER_COLOR around the SQUARE_COLOR interior. Without it the whole square
// is SQUARE_COLOR.
//
// Debug outputs dbg_pos_x/dbg_pos_y/dbg_dir_x/dbg_dir_y expose the position
// registers and both direction FSM states.
//
// Handshake note: there is no valid/ready flow here. The pixel stream is
// free-running, one coordinate per clk_pix cycle. 'frame' is a
// single-cycle strobe that is consumed on the edge where it is sampled high.
// That consumption only takes effect when move_en is also high.

module bouncing_square #(
   parameter int          H_RES            = 640,
   parameter int          V_RES            = 480,
   parameter int          SIZE             = 64,
   parameter int          SPEED            = 2,
   parameter int          X0               = 0,
   parameter int          Y0               = 0,
   parameter logic [2:0]  SQUARE_COLOR     = 3'b111,
   parameter logic [2:0]  BACKGROUND_COLOR = 3'b101,
   parameter int          BORDER           = 4,
   parameter logic [2:0]  BORDER_COLOR     = 3'b100
) (
   input  logic        clk_pix,
   input  logic        rst_pix,
   input  logic [9:0]  sx,
   input  logic [9:0]  sy,
   input  logic        frame,
   input  logic        move_en,
   output logic [2:0]  paint_rgb,
   output logic        in_square,
   output logic        bounce,
   output logic [9:0]  dbg_pos_x,
   output logic [9:0]  dbg_pos_y,
   output logic        dbg_dir_x,
   output logic        dbg_dir_y
);

   // Direction FSM encoding, shared by both axes.
   // X: forward = right, reverse = left. Y: forward = down, reverse = up.
   localparam logic [0:0] DIR_FWD = 1'b0;
   localparam logic [0:0] DIR_REV = 1'b1;

   // All geometry uses 11 bits, so sums such as pos + SIZE - 1 cannot wrap.
   localparam logic [10:0] LP_X_MAX  = 11'(H_RES - SIZE);
   localparam logic [10:0] LP_Y_MAX  = 11'(V_RES - SIZE);
   localparam logic [10:0] LP_SPEED  = 11'(SPEED);
   localparam logic [10:0] LP_SIZE   = 11'(SIZE);
   localparam logic [10:0] LP_BORDER = 11'(BORDER);
   localparam logic [9:0]  LP_X0     = 10'(X0);
   localparam logic [9:0]  LP_Y0     = 10'(Y0);

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   logic [9:0] r_pos_x;
   logic [9:0] r_pos_y;
   logic [0:0] r_dir_x;
   logic [0:0] r_dir_y;
   logic [2:0] r_paint_rgb;
   logic       r_in_square;
   logic       r_bounce;

   // ------------------------------------------------------------------
   // Next-state wires
   // ------------------------------------------------------------------
   logic [9:0] w_nx_pos_x;
   logic [0:0] w_nx_dir_x;
   logic       w_bounce_x;
   logic [9:0] w_nx_pos_y;
   logic [0:0] w_nx_dir_y;
   logic       w_bounce_y;
   logic       w_step;

   // ------------------------------------------------------------------
   // Pixel classification wires
   // ------------------------------------------------------------------
   logic [10:0] w_sx;
   logic [10:0] w_sy;
   logic [10:0] w_left;
   logic [10:0] w_right;
   logic [10:0] w_top;
   logic [10:0] w_bottom;
   logic        w_in_x;
   logic        w_in_y;
   logic        w_inside;
   logic        w_on_border;
   logic        w_use_border;
   logic [2:0]  w_color;

   // The square only moves when a frame strobe arrives while movement is enabled.
   assign w_step = frame & move_en;

   // X-axis direction FSM: step, or clamp onto the edge and reverse.
   always_comb begin
      w_nx_pos_x = r_pos_x;
      w_nx_dir_x = r_dir_x;
      w_bounce_x = 1'b0;
      if (r_dir_x == DIR_FWD) begin
         if (({1'b0, r_pos_x} + LP_SPEED) >= LP_X_MAX) begin
            w_nx_pos_x = LP_X_MAX[9:0];
            w_nx_dir_x = DIR_REV;
            w_bounce_x = 1'b1;
         end else begin
            w_nx_pos_x = r_pos_x + LP_SPEED[9:0];
         end
      end else begin
         if ({1'b0, r_pos_x} <= LP_SPEED) begin
            w_nx_pos_x = 10'd0;
            w_nx_dir_x = DIR_FWD;
            w_bounce_x = 1'b1;
         end else begin
            w_nx_pos_x = r_pos_x - LP_SPEED[9:0];
         end
      end
   end

   // Y-axis direction FSM: same rules as X, against the vertical limit.
   always_comb begin
      w_nx_pos_y = r_pos_y;
      w_nx_dir_y = r_dir_y;
      w_bounce_y = 1'b0;
      if (r_dir_y == DIR_FWD) begin
         if (({1'b0, r_pos_y} + LP_SPEED) >= LP_Y_MAX) begin
            w_nx_pos_y = LP_Y_MAX[9:0];
            w_nx_dir_y = DIR_REV;
            w_bounce_y = 1'b1;
         end else begin
            w_nx_pos_y = r_pos_y + LP_SPEED[9:0];
         end
      end else begin
         if ({1'b0, r_pos_y} <= LP_SPEED) begin
            w_nx_pos_y = 10'd0;
            w_nx_dir_y = DIR_FWD;
            w_bounce_y = 1'b1;
         end else begin
            w_nx_pos_y = r_pos_y - LP_SPEED[9:0];
         end
      end
   end

   // Position and direction state. These update only on a qualifying frame strobe.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         r_pos_x <= LP_X0;
         r_pos_y <= LP_Y0;
         r_dir_x <= DIR_FWD;
         r_dir_y <= DIR_FWD;
      end else if (w_step) begin
         r_pos_x <= w_nx_pos_x;
         r_pos_y <= w_nx_pos_y;
         r_dir_x <= w_nx_dir_x;
         r_dir_y <= w_nx_dir_y;
      end
   end

   // Bounce strobe: one cycle after a qualifying frame where either axis reversed.
   // A corner hit, where both axes reverse, still gives a single cycle.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         r_bounce <= 1'b0;
      end else begin
         r_bounce <= w_step & (w_bounce_x | w_bounce_y);
      end
   end

   // Square extents in 11-bit space. The right and bottom limits are inclusive.
   assign w_sx     = {1'b0, sx};
   assign w_sy     = {1'b0, sy};
   assign w_left   = {1'b0, r_pos_x};
   assign w_top    = {1'b0, r_pos_y};
   assign w_right  = w_left + LP_SIZE - 11'd1;
   assign w_bottom = w_top  + LP_SIZE - 11'd1;

   assign w_in_x   = (w_sx >= w_left) && (w_sx <= w_right);
   assign w_in_y   = (w_sy >= w_top)  && (w_sy <= w_bottom);
   assign w_inside = w_in_x & w_in_y;

   // A pixel is on the border if it lies inside the square and within BORDER
   // pixels of any of its four edges.
   assign w_on_border = w_inside &&
                        ((w_sx < (w_left + LP_BORDER)) ||
                         (w_sx > (w_right - LP_BORDER)) ||
                         (w_sy < (w_top + LP_BORDER)) ||
                         (w_sy > (w_bottom - LP_BORDER)));

`ifdef SQUARE_BORDER_EN
   assign w_use_border = w_on_border;
`else
   // The border geometry is computed in both builds. Here it never reaches
   // the colour mux, so synthesis removes it.
   assign w_use_border = w_on_border & 1'b0;
`endif

   // Colour select: border, then fill, then background.
   always_comb begin
      w_color = BACKGROUND_COLOR;
      if (w_inside) begin
         w_color = w_use_border ? BORDER_COLOR : SQUARE_COLOR;
      end
   end

   // Registered paint outputs. They are computed from the position held
   // before this edge, so a moving edge does not affect the current pixel.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         r_paint_rgb <= BACKGROUND_COLOR;
         r_in_square <= 1'b0;
      end else begin
         r_paint_rgb <= w_color;
         r_in_square <= w_inside;
      end
   end

   assign paint_rgb = r_paint_rgb;
   assign in_square = r_in_square;
   assign bounce    = r_bounce;
   assign dbg_pos_x = r_pos_x;
   assign dbg_pos_y = r_pos_y;
   assign dbg_dir_x = r_dir_x;
   assign dbg_dir_y = r_dir_y;

endmodule

// File: doc/bouncing_square.md
# bouncing_square

Parametrised sprite painter for the VGA pixel pipeline: draws a solid square of configurable size and colour over a background. It moves the square by a fixed step once per frame and reverses direction at each screen edge. It sits between the display timing generator (which supplies `sx`, `sy` and a per-frame pulse) and the RGB output stage. Its registered colour output lines up with a one-cycle-delayed sync path.

## Interface
Parameters:
- `H_RES`, 640: active pixels per line.
- `V_RES`, 480: active lines per frame.
- `SIZE`, 64: square side in pixels; must satisfy 1 ≤ SIZE < V_RES ≤ H_RES.
- `SPEED`, 2: pixels moved per frame on each axis; 1 ≤ SPEED < V_RES − SIZE.
- `X0`, 0: reset x position of the top-left corner; ≤ H_RES − SIZE.
- `Y0`, 0: reset y position of the top-left corner; ≤ V_RES − SIZE.
- `SQUARE_COLOR`, 3'b111: square fill colour.
- `BACKGROUND_COLOR`, 3'b101: colour outside the square.
- `BORDER`, 4: border width in pixels; used only with `SQUARE_BORDER_EN`; 2·BORDER < SIZE.
- `BORDER_COLOR`, 3'b100: border colour.

Ports:
- `clk_pix` in 1: pixel clock.
- `rst_pix` in 1: reset, asynchronous, active-high.
- `sx` in 10: current horizontal pixel coordinate.
- `sy` in 10: current vertical pixel coordinate.
- `frame` in 1: one-cycle pulse, once per frame, asserted during vertical blanking.
- `move_en` in 1: when low, the square freezes in place (painting continues).
- `paint_rgb` out 3: registered pixel colour.
- `in_square` out 1: registered flag; current pixel lies inside the square.
- `bounce` out 1: one-cycle pulse on any edge reversal.

## Operation
- State registers:
  - `pos_x`, `pos_y`: 10 bits each, top-left corner.
  - `dir_x`: 0 = right, 1 = left.
  - `dir_y`: 0 = down, 1 = up.
- Reset values: `pos_x`=X0, `pos_y`=Y0, `dir_x`=0, `dir_y`=0, `paint_rgb`=BACKGROUND_COLOR, `in_square`=0, `bounce`=0.
- Inside test: `pos_x` ≤ `sx` ≤ `pos_x`+SIZE−1 and `pos_y` ≤ `sy` ≤ `pos_y`+SIZE−1. Evaluate with 11-bit arithmetic so there is no wrap.
- Position update occurs only when `frame` && `move_en`. Each axis is an independent 2-state FSM (forward/reverse). X axis:
  - Right: if `pos_x`+SPEED ≥ H_RES−SIZE, then `pos_x` ← H_RES−SIZE and `dir_x` ← 1 (bounce). Otherwise `pos_x` ← `pos_x`+SPEED.
  - Left: if `pos_x` ≤ SPEED, then `pos_x` ← 0 and `dir_x` ← 0 (bounce). Otherwise `pos_x` ← `pos_x`−SPEED.
- Y axis: same rules using V_RES.
- Clamping makes the square land exactly on the edge. It never exceeds the screen bounds.
- `bounce` is asserted for the cycle after a qualifying `frame` if either axis bounced. A corner hit (both axes reverse) gives a single pulse.
- `frame` with `move_en` low: no position or direction change, and `bounce` stays 0.
- `sx`/`sy` outside the active area are painted as normal. Blanking is the downstream stage's responsibility.
- Reset asserted mid-frame: all registers return to reset values immediately. After release, movement resumes from (X0, Y0) at the next `frame`.

## Timing
- `paint_rgb` and `in_square` have 1-cycle latency from `sx`/`sy`.
- Position registers update on the `clk_pix` edge where `frame` is sampled high. Pixels on that same edge use the old position.
- `bounce` is high for the cycle right after that edge.
- `frame` pulses on consecutive cycles are legal; each one moves the square once.
- No combinational path from any input to any output.

## Configuration
- Macro: `SQUARE_BORDER_EN`.
- Defined: inside pixels within BORDER of any square edge paint BORDER_COLOR; the interior paints SQUARE_COLOR. `in_square` covers both border and interior.
- Undefined: the whole square paints SQUARE_COLOR, and BORDER/BORDER_COLOR are ignored.

## Test plan
- Reset with default parameters: `paint_rgb`=3'b101, `in_square`=0. Sample (sx,sy)=(0,0) → 3'b111 one cycle later; (64,0) → 3'b101; (63,63) → 3'b111.
- 10 `frame` pulses with `move_en`=1 → `pos` = (20,20). Pixel (20,20) is in the square and (19,20) is not.
- X0=574, SPEED=2, one `frame` → `pos_x`=576, `dir_x`=1, single `bounce` pulse. Next `frame` → `pos_x`=574.
- X0=576, Y0=416, dir_y forced down by reset → first `frame` flips both axes with exactly one `bounce` cycle, and the position stays (576,416).
- `move_en`=0 across 5 `frame` pulses → position unchanged and `bounce` never asserted. Then assert `rst_pix` mid-line → outputs return to reset values in the same cycle.
- With `SQUARE_BORDER_EN`, default position: (2,30) → 3'b100, (30,30) → 3'b111, (70,30) → 3'b101.
